// File: rtl/add_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : add_share_arb
// Description : One W-bit adder shared by NREQ requesters through a
//               round-robin grant and a single-entry result slot.
// Revision    : 1.0  initial release
// ============================================================================
module add_share_arb #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*W-1:0]       req_a,
    input  logic [NREQ*W-1:0]       req_b,
    input  logic [NREQ-1:0]         req_ci,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [W-1:0]            rsp_sum,
    output logic                    rsp_co,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [15:0]             op_count
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           state_q;
    logic             rsp_valid_q;
    logic [W-1:0]     sum_q;
    logic             co_q;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   ptr_d;
    logic [15:0]      cnt_q;
    logic [15:0]      cnt_d;

    logic             w_slot_free;
    logic             w_hi_found;
    logic             w_lo_found;
    logic [IDW-1:0]   w_hi_idx;
    logic [IDW-1:0]   w_lo_idx;
    logic             w_found;
    logic [IDW-1:0]   w_gnt_idx;
    logic [NREQ-1:0]  w_ready;
    logic             w_accept;
    logic [W-1:0]     w_op_a;
    logic [W-1:0]     w_op_b;
    logic             w_op_ci;
    logic [W:0]       w_add;

    // The slot may be refilled in the same cycle its current result drains.
    assign w_slot_free = (state_q == ST_EMPTY) || rsp_ready;

    // Two searches, both lowest-index-first: one restricted to indices at or
    // above ptr, one over all requesters for the wrap-around case.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = IDW'(i);
                if (IDW'(i) >= ptr_q) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = IDW'(i);
                end
            end
        end
    end

    assign w_found   = w_hi_found || w_lo_found;
    assign w_gnt_idx = w_hi_found ? w_hi_idx : w_lo_idx;

    always_comb begin
        w_ready = '0;
        if (w_slot_free && w_found && !rst) begin
            w_ready[w_gnt_idx] = 1'b1;
        end
    end

    assign req_ready = w_ready;
    assign w_accept  = |(w_ready & req_valid);

    always_comb begin
        w_op_a  = '0;
        w_op_b  = '0;
        w_op_ci = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == w_gnt_idx) begin
                w_op_a  = req_a[i*W +: W];
                w_op_b  = req_b[i*W +: W];
                w_op_ci = req_ci[i];
            end
        end
    end

    // The single shared adder.
    assign w_add = {1'b0, w_op_a} + {1'b0, w_op_b} + {{W{1'b0}}, w_op_ci};

    assign ptr_d = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : (w_gnt_idx + 1'b1);
    assign cnt_d = cnt_q + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            rsp_valid_q <= 1'b0;
            sum_q       <= '0;
            co_q        <= 1'b0;
            id_q        <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
        end else begin
            if (w_accept) begin
                state_q     <= ST_FULL;
                rsp_valid_q <= 1'b1;
                sum_q       <= w_add[W-1:0];
                co_q        <= w_add[W];
                id_q        <= w_gnt_idx;
                ptr_q       <= ptr_d;
                cnt_q       <= cnt_d;
            end else if (state_q == ST_FULL && rsp_ready) begin
                state_q     <= ST_EMPTY;
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = sum_q;
    assign rsp_co    = co_q;
    assign rsp_id    = id_q;
    assign op_count  = cnt_q;

endmodule
`default_nettype wire
